// File: rtl/ov7670_cfg_ctrl.sv
// OV7670 power-up configuration sequencer: walks the register LUT and hands each
// {reg_addr, reg_data} entry to the SCCB write master, with delays, retries and status.
module ov7670_cfg_ctrl #(
    parameter int unsigned LUT_SIZE  = 165,
    parameter int unsigned PWR_DLY   = 1000000,
    parameter int unsigned RST_DLY   = 50000,
    parameter int unsigned GAP_DLY   = 100,
    parameter int unsigned MAX_RETRY = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cfg_start,
    output logic [7:0]  lut_index,
    input  logic [15:0] lut_data,
    output logic        i2c_req,
    output logic [7:0]  i2c_addr,
    output logic [7:0]  i2c_wdata,
    input  logic        i2c_ack,
    input  logic        i2c_nack,
    output logic        cfg_busy,
    output logic        cfg_done,
    output logic        cfg_err,
    output logic [7:0]  cfg_cnt
);

    typedef enum logic [2:0] {
        PWR_WAIT,
        FETCH,
        REQ,
        GAP,
        RST_WAIT,
        DONE,
        ERR
    } state_t;

    localparam logic [23:0] PWR_LAST    = 24'(PWR_DLY > 0 ? PWR_DLY - 1 : 0);
    localparam logic [23:0] RST_LAST    = 24'(RST_DLY > 0 ? RST_DLY - 1 : 0);
    localparam logic [23:0] GAP_LAST    = 24'(GAP_DLY > 0 ? GAP_DLY - 1 : 0);
    localparam logic [7:0]  END_INDEX   = 8'(LUT_SIZE);
    localparam logic [7:0]  RETRY_LIMIT = 8'(MAX_RETRY);

    state_t      state;
    state_t      state_nxt;
    logic [23:0] dly_cnt;
    logic [7:0]  retry;
    logic        soft_rst;
    logic        lut_end;

    // COM7 (0x12) with bit7 set resets the sensor, which then needs its settle time
    assign soft_rst = (i2c_addr == 8'h12) && i2c_wdata[7];
    assign lut_end  = (lut_index == END_INDEX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= PWR_WAIT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            PWR_WAIT: if (dly_cnt == PWR_LAST) state_nxt = FETCH;
            FETCH:    state_nxt = REQ;
            REQ: begin
                if (i2c_ack) begin
                    if (i2c_nack) begin
                        state_nxt = (retry + 8'd1 == RETRY_LIMIT) ? ERR : GAP;
                    end else begin
                        state_nxt = soft_rst ? RST_WAIT : GAP;
                    end
                end
            end
            GAP:      if (dly_cnt == GAP_LAST) state_nxt = lut_end ? DONE : FETCH;
            RST_WAIT: if (dly_cnt == RST_LAST) state_nxt = lut_end ? DONE : FETCH;
            DONE:     if (cfg_start) state_nxt = FETCH;
            ERR:      if (cfg_start) state_nxt = FETCH;
            default:  state_nxt = PWR_WAIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dly_cnt   <= '0;
            retry     <= '0;
            lut_index <= '0;
            cfg_cnt   <= '0;
            i2c_req   <= 1'b0;
            i2c_addr  <= '0;
            i2c_wdata <= '0;
            cfg_busy  <= 1'b0;
            cfg_done  <= 1'b0;
            cfg_err   <= 1'b0;
        end else begin
            dly_cnt  <= (state_nxt != state) ? '0 : dly_cnt + 24'd1;
            // Status and request flags follow the next state so they line up with it
            i2c_req  <= (state_nxt == REQ);
            cfg_busy <= (state_nxt != DONE) && (state_nxt != ERR);
            cfg_done <= (state_nxt == DONE);
            cfg_err  <= (state_nxt == ERR);

            if (state == FETCH) begin
                i2c_addr  <= lut_data[15:8];
                i2c_wdata <= lut_data[7:0];
            end

            if (state == REQ && i2c_ack) begin
                if (i2c_nack) begin
                    retry <= retry + 8'd1;
                end else begin
                    retry     <= '0;
                    lut_index <= lut_index + 8'd1;
                    cfg_cnt   <= cfg_cnt + 8'd1;
                end
            end

            if ((state == DONE || state == ERR) && cfg_start) begin
                retry     <= '0;
                lut_index <= '0;
                cfg_cnt   <= '0;
            end
        end
    end

endmodule

// File: tb/tb_ov7670_cfg_ctrl.sv
// Directed bench for ov7670_cfg_ctrl: a request table drives the SCCB responder side,
// with hand-written sequences for completion, error, restart and mid-request reset.
module tb_ov7670_cfg_ctrl;

    logic        clk;
    logic        rst_n;
    logic        cfg_start;
    logic [7:0]  lut_index;
    logic [15:0] lut_data;
    logic        i2c_req;
    logic [7:0]  i2c_addr;
    logic [7:0]  i2c_wdata;
    logic        i2c_ack;
    logic        i2c_nack;
    logic        cfg_busy;
    logic        cfg_done;
    logic        cfg_err;
    logic [7:0]  cfg_cnt;

    int checks   = 0;
    int failures = 0;
    int elapsed  = 0;

    logic [15:0] lut_mem [4];

    ov7670_cfg_ctrl #(
        .LUT_SIZE  (4),
        .PWR_DLY   (10),
        .RST_DLY   (20),
        .GAP_DLY   (2),
        .MAX_RETRY (3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_start (cfg_start),
        .lut_index (lut_index),
        .lut_data  (lut_data),
        .i2c_req   (i2c_req),
        .i2c_addr  (i2c_addr),
        .i2c_wdata (i2c_wdata),
        .i2c_ack   (i2c_ack),
        .i2c_nack  (i2c_nack),
        .cfg_busy  (cfg_busy),
        .cfg_done  (cfg_done),
        .cfg_err   (cfg_err),
        .cfg_cnt   (cfg_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        lut_data = 16'h0000;
        if (lut_index < 8'd4) lut_data = lut_mem[lut_index[1:0]];
    end

    // One record per expected request: responder inputs, then the expected request contents.
    // exp_wait counts negedges from the previous ack (or release/start) to req being seen high.
    typedef struct {
        logic       nack;
        int         dly;
        bit         stray;
        bit         start;
        int         exp_wait;
        logic [7:0] exp_addr;
        logic [7:0] exp_data;
        logic [7:0] exp_idx;
        logic [7:0] exp_cnt;
    } vec_t;

    vec_t vecs [19];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic serve(input int i);
        vec_t v;
        v = vecs[i];
        while (i2c_req !== 1'b1 && elapsed < 100) begin
            @(negedge clk);
            elapsed++;
        end
        if (i2c_req !== 1'b1) begin
            chk($sformatf("v%0d_req_timeout", i), 32'(i2c_req), 32'd1);
            return;
        end
        chk($sformatf("v%0d_req_wait", i), 32'(elapsed), 32'(v.exp_wait));
        chk($sformatf("v%0d_addr", i), 32'(i2c_addr), 32'(v.exp_addr));
        chk($sformatf("v%0d_wdata", i), 32'(i2c_wdata), 32'(v.exp_data));
        chk($sformatf("v%0d_lut_index", i), 32'(lut_index), 32'(v.exp_idx));
        chk($sformatf("v%0d_cfg_cnt", i), 32'(cfg_cnt), 32'(v.exp_cnt));
        chk($sformatf("v%0d_busy", i), 32'(cfg_busy), 32'd1);
        for (int d = 0; d < v.dly; d++) begin
            if (v.start && d == 0) cfg_start = 1'b1;
            @(negedge clk);
            cfg_start = 1'b0;
            chk($sformatf("v%0d_req_hold", i), 32'({i2c_req, i2c_addr, i2c_wdata}),
                32'({1'b1, v.exp_addr, v.exp_data}));
        end
        i2c_ack  = 1'b1;
        i2c_nack = v.nack;
        @(negedge clk);
        i2c_ack  = 1'b0;
        i2c_nack = 1'b0;
        elapsed  = 1;
        chk($sformatf("v%0d_req_drop", i), 32'(i2c_req), 32'd0);
        if (v.stray) begin
            i2c_ack = 1'b1;
            @(negedge clk);
            i2c_ack = 1'b0;
            elapsed++;
        end
    endtask

    task automatic wait_end(input string name, input logic exp_done, input logic [7:0] exp_idx,
                            input logic [7:0] exp_cnt);
        int n;
        n = 0;
        while (!(cfg_done === 1'b1 || cfg_err === 1'b1) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_done"}, 32'(cfg_done), 32'(exp_done));
        chk({name, "_err"}, 32'(cfg_err), 32'(!exp_done));
        chk({name, "_busy"}, 32'(cfg_busy), 32'd0);
        chk({name, "_req"}, 32'(i2c_req), 32'd0);
        chk({name, "_lut_index"}, 32'(lut_index), 32'(exp_idx));
        chk({name, "_cfg_cnt"}, 32'(cfg_cnt), 32'(exp_cnt));
    endtask

    task automatic restart(input string name);
        cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        elapsed   = 1;
        chk({name, "_flags"}, 32'({cfg_busy, cfg_done, cfg_err}), 32'b100);
        chk({name, "_index_cnt"}, 32'({lut_index, cfg_cnt}), 32'h0000);
    endtask

    task automatic check_reset_values(input string name);
        chk({name, "_req"}, 32'(i2c_req), 32'd0);
        chk({name, "_addr_data"}, 32'({i2c_addr, i2c_wdata}), 32'h0000);
        chk({name, "_index_cnt"}, 32'({lut_index, cfg_cnt}), 32'h0000);
        chk({name, "_flags"}, 32'({cfg_busy, cfg_done, cfg_err}), 32'b000);
    endtask

    initial begin
        lut_mem[0] = 16'h1280;
        lut_mem[1] = 16'h1214;
        lut_mem[2] = 16'h3a04;
        lut_mem[3] = 16'h40d0;

        //           nack  dly stray start wait addr   data   idx    cnt
        vecs[0]  = '{1'b0, 5,  1,    0,    11,  8'h12, 8'h80, 8'd0, 8'd0};
        vecs[1]  = '{1'b0, 5,  0,    1,    22,  8'h12, 8'h14, 8'd1, 8'd1};
        vecs[2]  = '{1'b1, 5,  0,    0,    4,   8'h3a, 8'h04, 8'd2, 8'd2};
        vecs[3]  = '{1'b0, 0,  0,    0,    4,   8'h3a, 8'h04, 8'd2, 8'd2};
        vecs[4]  = '{1'b0, 5,  0,    0,    4,   8'h40, 8'hd0, 8'd3, 8'd3};
        vecs[5]  = '{1'b0, 5,  0,    0,    2,   8'h12, 8'h80, 8'd0, 8'd0};
        vecs[6]  = '{1'b0, 3,  0,    0,    22,  8'h12, 8'h14, 8'd1, 8'd1};
        vecs[7]  = '{1'b0, 0,  0,    0,    4,   8'h3a, 8'h04, 8'd2, 8'd2};
        vecs[8]  = '{1'b0, 5,  0,    0,    4,   8'h40, 8'hd0, 8'd3, 8'd3};
        vecs[9]  = '{1'b0, 5,  0,    0,    2,   8'h12, 8'h80, 8'd0, 8'd0};
        vecs[10] = '{1'b1, 2,  0,    0,    22,  8'h12, 8'h14, 8'd1, 8'd1};
        vecs[11] = '{1'b1, 5,  0,    0,    4,   8'h12, 8'h14, 8'd1, 8'd1};
        vecs[12] = '{1'b1, 0,  0,    0,    4,   8'h12, 8'h14, 8'd1, 8'd1};
        vecs[13] = '{1'b0, 5,  0,    0,    2,   8'h12, 8'h80, 8'd0, 8'd0};
        vecs[14] = '{1'b0, 5,  0,    0,    22,  8'h12, 8'h14, 8'd1, 8'd1};
        vecs[15] = '{1'b0, 5,  0,    0,    11,  8'h12, 8'h80, 8'd0, 8'd0};
        vecs[16] = '{1'b0, 5,  0,    0,    22,  8'h12, 8'h14, 8'd1, 8'd1};
        vecs[17] = '{1'b0, 5,  0,    0,    4,   8'h3a, 8'h04, 8'd2, 8'd2};
        vecs[18] = '{1'b0, 5,  0,    0,    4,   8'h40, 8'hd0, 8'd3, 8'd3};

        rst_n     = 1'b0;
        cfg_start = 1'b0;
        i2c_ack   = 1'b0;
        i2c_nack  = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values("reset");

        // First run: soft-reset settle after 0x12/0x80, NACK-then-ACK on entry 2,
        // ignored cfg_start in REQ, stray ack in RST_WAIT, same-cycle ack
        rst_n   = 1'b1;
        elapsed = 0;
        @(negedge clk);
        elapsed = 1;
        chk("pwr_wait_busy", 32'(cfg_busy), 32'd1);
        for (int i = 0; i <= 4; i++) serve(i);
        wait_end("run1", 1'b1, 8'd4, 8'd4);

        restart("start_from_done");
        for (int i = 5; i <= 8; i++) serve(i);
        wait_end("run2", 1'b1, 8'd4, 8'd4);

        // Entry 1 is NACKed on every attempt: exactly three requests, then ERR
        restart("start_nack_run");
        for (int i = 9; i <= 12; i++) serve(i);
        chk("err_flags", 32'({cfg_busy, cfg_done, cfg_err, i2c_req}), 32'b0010);
        chk("err_index_cnt", 32'({lut_index, cfg_cnt}), 32'h0101);
        begin
            int extra;
            extra = 0;
            repeat (30) begin
                @(negedge clk);
                if (i2c_req === 1'b1) extra++;
            end
            chk("err_no_more_req", 32'(extra), 32'd0);
            chk("err_held", 32'({cfg_err, lut_index}), 32'h101);
        end

        restart("start_from_err");
        for (int i = 13; i <= 14; i++) serve(i);

        // Reset while entry 2 is being requested drops req without waiting for a clock
        while (i2c_req !== 1'b1 && elapsed < 100) begin
            @(negedge clk);
            elapsed++;
        end
        chk("mid_req_addr", 32'({i2c_req, i2c_addr}), 32'h13a);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("async_reset");
        repeat (2) @(negedge clk);
        rst_n   = 1'b1;
        elapsed = 0;
        for (int i = 15; i <= 18; i++) serve(i);
        wait_end("run_after_reset", 1'b1, 8'd4, 8'd4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
